// File: rtl/lane_obstacle_gen.sv
// Frogger lane engine: rotating log/car occupancy per row, tile lookup for the renderer,
// frog collision/log flags and log-carry pulses. Define FROGGER_DROWN_EN to make water lethal.
module lane_obstacle_gen #(
  parameter int c_TICK_COUNT  = 12500000,
  parameter int c_GAME_WIDTH  = 20,
  parameter int c_GAME_HEIGHT = 15
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [5:0] i_Frogger_X,
  input  logic [5:0] i_Frogger_Y,
  input  logic [5:0] i_Col_Count_Div,
  input  logic [5:0] i_Row_Count_Div,
  output logic [3:0] o_Bitmap_Data,
  output logic       o_Collided,
  output logic       o_On_Log,
  output logic       o_Carry_Left,
  output logic       o_Carry_Right
);

  localparam int W  = c_GAME_WIDTH;
  localparam int CW = (c_TICK_COUNT > 1) ? $clog2(c_TICK_COUNT) : 1;
  localparam logic [W-1:0] RIVER_INIT = W'(20'hF0F0F);
  localparam logic [W-1:0] ROAD_INIT  = W'(20'h08421);

  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [W-1:0]  lane     [1:13];
  logic [1:0]    lane_div [1:13];
  logic          lane_rot [1:13];

  logic [W-1:0]  frog_lane, query_lane, frog_shift, query_shift;
  logic          frog_rot, frog_in_x, frog_river, frog_road;
  logic          on_log_next, collided_next, carry_left_next, carry_right_next;
  logic [3:0]    bitmap_next;

  // Lane r moves on every ((r mod 3)+1)-th tick, so its divider rolls over at r mod 3.
  always_comb begin
    tick = (tick_cnt == CW'(c_TICK_COUNT - 1));
    for (int r = 1; r <= 13; r++) begin
      lane_rot[r] = tick && (r != 6) && (lane_div[r] == 2'(r % 3));
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      tick_cnt <= '0;
      for (int r = 1; r <= 13; r++) begin
        lane_div[r] <= '0;
        if (r <= 5)
          lane[r] <= RIVER_INIT;
        else if (r >= 7)
          lane[r] <= ROAD_INIT;
        else
          lane[r] <= '0;
      end
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick) begin
        for (int r = 1; r <= 13; r++) begin
          if (r != 6) begin
            if (lane_rot[r]) begin
              lane_div[r] <= '0;
              // Odd rows drift left (bit n takes bit n+1), even rows drift right.
              if (r % 2 == 1)
                lane[r] <= {lane[r][0], lane[r][W-1:1]};
              else
                lane[r] <= {lane[r][W-2:0], lane[r][W-1]};
            end else begin
              lane_div[r] <= lane_div[r] + 2'd1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    frog_lane  = '0;
    query_lane = '0;
    frog_rot   = 1'b0;
    for (int r = 1; r <= 13; r++) begin
      if (r != 6) begin
        if (i_Frogger_Y == 6'(r)) begin
          frog_lane = lane[r];
          frog_rot  = lane_rot[r];
        end
        if (i_Row_Count_Div == 6'(r))
          query_lane = lane[r];
      end
    end
    frog_shift  = frog_lane >> i_Frogger_X;
    query_shift = query_lane >> i_Col_Count_Div;

    frog_in_x  = (i_Frogger_X < 6'(W));
    frog_river = frog_in_x && (i_Frogger_Y >= 6'd1) && (i_Frogger_Y <= 6'd5);
    frog_road  = frog_in_x && (i_Frogger_Y >= 6'd7) && (i_Frogger_Y <= 6'd13);

    on_log_next = frog_river && frog_shift[0];
`ifdef FROGGER_DROWN_EN
    collided_next = (frog_road && frog_shift[0]) || (frog_river && !frog_shift[0]);
`else
    collided_next = frog_road && frog_shift[0];
`endif
    // Carry only when the frog was standing on a log as its lane moves.
    carry_left_next  = on_log_next && frog_rot && i_Frogger_Y[0];
    carry_right_next = on_log_next && frog_rot && !i_Frogger_Y[0];

    bitmap_next = 4'd0;
    if ((i_Col_Count_Div >= 6'(W)) || (i_Row_Count_Div >= 6'(c_GAME_HEIGHT)))
      bitmap_next = 4'd15;
    else if (i_Row_Count_Div == 6'd0)
      bitmap_next = 4'd4;
    else if (i_Row_Count_Div <= 6'd5)
      bitmap_next = query_shift[0] ? 4'd5 : 4'd2;
    else if ((i_Row_Count_Div >= 6'd7) && (i_Row_Count_Div <= 6'd13))
      bitmap_next = query_shift[0] ? 4'd3 : 4'd1;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Bitmap_Data <= '0;
      o_Collided    <= 1'b0;
      o_On_Log      <= 1'b0;
      o_Carry_Left  <= 1'b0;
      o_Carry_Right <= 1'b0;
    end else begin
      o_Bitmap_Data <= bitmap_next;
      o_Collided    <= collided_next;
      o_On_Log      <= on_log_next;
      o_Carry_Left  <= carry_left_next;
      o_Carry_Right <= carry_right_next;
    end
  end

endmodule

// File: tb/tb_lane_obstacle_gen.sv
// Directed bench for lane_obstacle_gen with a 4-cycle movement tick.
module tb_lane_obstacle_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] fx = '0, fy = '0, qcol = '0, qrow = '0;
  logic [3:0] bmp;
  logic       coll, onlog, cl, cr;

  int checks   = 0;
  int failures = 0;

`ifdef FROGGER_DROWN_EN
  localparam logic DROWN = 1'b1;
`else
  localparam logic DROWN = 1'b0;
`endif

  typedef struct {
    logic [5:0] q_row;
    logic [5:0] q_col;
    logic [5:0] fx;
    logic [5:0] fy;
    logic [3:0] bmp;
    logic       coll;
    logic       onlog;
  } vec_t;

  vec_t vecs [8];

  lane_obstacle_gen #(
    .c_TICK_COUNT (4),
    .c_GAME_WIDTH (20),
    .c_GAME_HEIGHT(15)
  ) dut (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_Frogger_X    (fx),
    .i_Frogger_Y    (fy),
    .i_Col_Count_Div(qcol),
    .i_Row_Count_Div(qrow),
    .o_Bitmap_Data  (bmp),
    .o_Collided     (coll),
    .o_On_Log       (onlog),
    .o_Carry_Left   (cl),
    .o_Carry_Right  (cr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] r, input logic [5:0] c, input logic [5:0] x, input logic [5:0] y);
    qrow = r;
    qcol = c;
    fx   = x;
    fy   = y;
  endtask

  // Leaves the bench 1 time unit after the last reset edge with rst low.
  task automatic doReset();
    rst = 1'b1;
    step();
    checkOutput("rst_bmp", 32'(bmp), 0);
    checkOutput("rst_coll", 32'(coll), 0);
    checkOutput("rst_onlog", 32'(onlog), 0);
    checkOutput("rst_carry", 32'({cl, cr}), 0);
    step();
    rst = 1'b0;
  endtask

  task automatic runCarry(input logic [5:0] x, input logic [5:0] y, input int exp_cycle, input logic left);
    int lc, rc, first;
    lc = 0;
    rc = 0;
    first = -1;
    applyStimulus(6'd0, 6'd0, x, y);
    doReset();
    for (int k = 1; k <= 14; k++) begin
      step();
      if (cl) lc++;
      if (cr) rc++;
      if ((left ? cl : cr) && first < 0) first = k;
    end
    checkOutput($sformatf("carry_y%0d_pulses", y), 32'(left ? lc : rc), 1);
    checkOutput($sformatf("carry_y%0d_wrongdir", y), 32'(left ? rc : lc), 0);
    checkOutput($sformatf("carry_y%0d_cycle", y), 32'(first), 32'(exp_cycle));
  endtask

  initial begin
    logic [5:0] a_row [13];
    logic [5:0] a_col [13];
    int         a_bmp [13];

    vecs[0] = '{6'd7,  6'd0,  6'd5,  6'd7,  4'd3,  1'b1,  1'b0};
    vecs[1] = '{6'd7,  6'd1,  6'd4,  6'd14, 4'd1,  1'b0,  1'b0};
    vecs[2] = '{6'd0,  6'd0,  6'd0,  6'd1,  4'd4,  1'b0,  1'b1};
    vecs[3] = '{6'd20, 6'd0,  6'd4,  6'd1,  4'd15, DROWN, 1'b0};
    vecs[4] = '{6'd1,  6'd5,  6'd20, 6'd7,  4'd2,  1'b0,  1'b0};
    vecs[5] = '{6'd2,  6'd19, 6'd3,  6'd15, 4'd5,  1'b0,  1'b0};
    vecs[6] = '{6'd0,  6'd20, 6'd10, 6'd13, 4'd15, 1'b1,  1'b0};
    vecs[7] = '{6'd6,  6'd3,  6'd16, 6'd5,  4'd0,  1'b0,  1'b1};

    a_row = '{6'd3, 6'd3, 6'd3, 6'd3, 6'd3, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd2, 6'd2, 6'd2};
    a_col = '{6'd3, 6'd3, 6'd3, 6'd3, 6'd3, 6'd3, 6'd3, 6'd3, 6'd3, 6'd19, 6'd4, 6'd4, 6'd4};
    a_bmp = '{5, 5, 5, 5, 2, 5, 5, 5, 2, 5, 2, 2, 5};

    // Static lookups and frog flags before any watched row has moved.
    applyStimulus(6'd7, 6'd0, 6'd5, 6'd7);
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].q_row, vecs[i].q_col, vecs[i].fx, vecs[i].fy);
      step();
      checkOutput($sformatf("vec%0d_bmp", i), 32'(bmp), 32'(vecs[i].bmp));
      checkOutput($sformatf("vec%0d_coll", i), 32'(coll), 32'(vecs[i].coll));
      checkOutput($sformatf("vec%0d_onlog", i), 32'(onlog), 32'(vecs[i].onlog));
      checkOutput($sformatf("vec%0d_carry", i), 32'({cl, cr}), 0);
    end

    // Per-lane rotation rates and direction, frog riding row 3.
    applyStimulus(a_row[0], a_col[0], 6'd3, 6'd3);
    doReset();
    for (int k = 1; k <= 13; k++) begin
      applyStimulus(a_row[k-1], a_col[k-1], 6'd3, 6'd3);
      step();
      checkOutput($sformatf("rot_k%0d_bmp", k), 32'(bmp), 32'(a_bmp[k-1]));
      checkOutput($sformatf("rot_k%0d_cl", k), 32'(cl), 32'(k == 4));
      checkOutput($sformatf("rot_k%0d_cr", k), 32'(cr), 0);
      checkOutput($sformatf("rot_k%0d_onlog", k), 32'(onlog), 32'(k <= 4));
    end

    runCarry(6'd0, 6'd1, 8, 1'b1);
    runCarry(6'd0, 6'd2, 12, 1'b0);

    // Reset mid-count after one tick: lanes reload and the tick phase restarts.
    applyStimulus(6'd3, 6'd3, 6'd63, 6'd63);
    doReset();
    repeat (6) step();
    checkOutput("midrst_pre_bmp", 32'(bmp), 2);
    rst = 1'b1;
    step();
    checkOutput("midrst_hold_bmp", 32'(bmp), 0);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      checkOutput($sformatf("midrst_k%0d_bmp", k), 32'(bmp), (k <= 4) ? 5 : 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
